mem_io_bridge: RTL and testbench

MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

---
 rtl/mem_io_bridge.sv | 174 +++++++++++++++++
 tb/tb_mem_io_bridge.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bridge.sv
// CPU bridge to byte RAM and memory-mapped I/O, with a TX FIFO, a cycle counter and a 1-cycle read mux.
// Optional UART RX read path at 0x30000 is enabled by defining IO_RX_EN.
module mem_io_bridge #(
    parameter int unsigned TX_FIFO_WIDTH  = 3,
    parameter int unsigned RAM_ADDR_WIDTH = 17
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic [31:0]               cpu_a,
    input  logic [7:0]                cpu_dout,
    input  logic                      cpu_wr,
    output logic [7:0]                cpu_din,
    output logic                      io_buffer_full,
    output logic                      ram_en,
    output logic                      ram_wr,
    output logic [RAM_ADDR_WIDTH-1:0] ram_a,
    output logic [7:0]                ram_din,
    input  logic [7:0]                ram_dout,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      rx_pop,
    output logic                      program_stop,
    output logic                      tx_overflow
);
    localparam int unsigned DEPTH       = 1 << TX_FIFO_WIDTH;
    localparam int unsigned CNT_W       = TX_FIFO_WIDTH + 1;
    localparam int unsigned ALMOST_FULL = DEPTH - 2;
    localparam logic [TX_FIFO_WIDTH-1:0] PTR_ONE = TX_FIFO_WIDTH'(1);
    localparam logic [CNT_W-1:0]         CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        SEL_ZERO, SEL_RAM, SEL_RX, SEL_CNT0, SEL_CNT1, SEL_CNT2, SEL_CNT3
    } sel_t;

    logic        is_io;
    logic [15:0] io_off;
    logic        io_wr;
    logic        io_rd;
    sel_t        sel;
    sel_t        sel_nxt;
    logic [31:0] counter;
    logic [31:0] snap;
    logic [7:0]  rx_sample;

    logic [7:0]               mem [DEPTH];
    logic [TX_FIFO_WIDTH-1:0] head;
    logic [TX_FIFO_WIDTH-1:0] tail;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         count_nxt;
    logic                     push;
    logic [7:0]               push_byte;
    logic                     pop;
    logic                     full;
    logic                     accept;

    // Address decode and combinational RAM request
    assign is_io   = cpu_a[17:16] == 2'b11;
    assign io_off  = cpu_a[15:0];
    assign io_wr   = rdy_in && is_io && cpu_wr;
    assign io_rd   = rdy_in && is_io && !cpu_wr;
    assign ram_en  = rdy_in && !is_io;
    assign ram_wr  = ram_en && cpu_wr;
    assign ram_a   = cpu_a[RAM_ADDR_WIDTH-1:0];
    assign ram_din = cpu_dout;

    // TX FIFO control; a push into a full FIFO is only accepted alongside a pop
    assign push      = io_wr && ((io_off == 16'h0000 && cpu_dout != 8'h00) || io_off == 16'h0004);
    assign push_byte = (io_off == 16'h0004) ? 8'h00 : cpu_dout;
    assign tx_valid  = count != '0;
    assign tx_data   = mem[head];
    assign pop       = tx_valid && tx_ready;
    assign full      = count == CNT_W'(DEPTH);
    assign accept    = push && (!full || pop);

    always_comb begin
        count_nxt = count;
        if (accept && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (!accept && pop) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // Read source for the next cycle; held while the CPU is stalled
    always_comb begin
        sel_nxt = sel;
        if (rdy_in) begin
            sel_nxt = SEL_ZERO;
            if (!cpu_wr) begin
                if (!is_io) begin
                    sel_nxt = SEL_RAM;
                end else begin
                    case (io_off)
`ifdef IO_RX_EN
                        16'h0000: sel_nxt = SEL_RX;
`endif
                        16'h0004: sel_nxt = SEL_CNT0;
                        16'h0005: sel_nxt = SEL_CNT1;
                        16'h0006: sel_nxt = SEL_CNT2;
                        16'h0007: sel_nxt = SEL_CNT3;
                        default:  sel_nxt = SEL_ZERO;
                    endcase
                end
            end
        end
    end

    always_comb begin
        cpu_din = 8'h00;
        case (sel)
            SEL_RAM:  cpu_din = ram_dout;
            SEL_RX:   cpu_din = rx_sample;
            SEL_CNT0: cpu_din = snap[7:0];
            SEL_CNT1: cpu_din = snap[15:8];
            SEL_CNT2: cpu_din = snap[23:16];
            SEL_CNT3: cpu_din = snap[31:24];
            default:  cpu_din = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (accept) begin
            mem[tail] <= push_byte;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            io_buffer_full <= 1'b0;
            tx_overflow    <= 1'b0;
            program_stop   <= 1'b0;
            counter        <= 32'd0;
            snap           <= 32'd0;
            sel            <= SEL_ZERO;
        end else begin
            if (accept) tail <= tail + PTR_ONE;
            if (pop)    head <= head + PTR_ONE;
            count          <= count_nxt;
            io_buffer_full <= count_nxt >= CNT_W'(ALMOST_FULL);
            if (push && full && !pop)            tx_overflow  <= 1'b1;
            if (io_wr && io_off == 16'h0004)     program_stop <= 1'b1;
            if (rdy_in)                          counter      <= counter + 32'd1;
            if (io_rd && io_off == 16'h0004)     snap         <= counter;
            sel <= sel_nxt;
        end
    end

`ifdef IO_RX_EN
    logic unused_bits;
    assign unused_bits = ^cpu_a[31:18];
    assign rx_pop      = io_rd && io_off == 16'h0000 && rx_valid;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_sample <= 8'h00;
        end else if (io_rd && io_off == 16'h0000) begin
            rx_sample <= rx_valid ? rx_data : 8'h00;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{cpu_a[31:18], rx_data, rx_valid};
    assign rx_pop      = 1'b0;
    assign rx_sample   = 8'h00;
`endif

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: vector table for RAM/IO reads plus TX FIFO, counter and reset sequences.
module tb_mem_io_bridge;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic        ram_en;
    logic        ram_wr;
    logic [16:0] ram_a;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = 8'h00;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        program_stop;
    logic        tx_overflow;

    int checks   = 0;
    int failures = 0;

    mem_io_bridge dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .io_buffer_full(io_buffer_full),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_a(ram_a), .ram_din(ram_din), .ram_dout(ram_dout),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
        .program_stop(program_stop), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Byte RAM with one-cycle read latency
    logic [7:0] ram_mem [131072];
    always @(posedge clk_in) begin
        if (ram_en) begin
            if (ram_wr) ram_mem[ram_a] <= ram_din;
            ram_dout <= ram_mem[ram_a];
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [7:0]  dout;
        logic        wr;
        logic        rdy;
        logic        en;
        logic        rwr;
        logic [7:0]  din;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [7:0] d, input logic wr);
        cpu_a    = a;
        cpu_dout = d;
        cpu_wr   = wr;
    endtask

    task automatic io_write(input logic [31:0] a, input logic [7:0] d);
        drive(a, d, 1'b1);
        step();
    endtask

    task automatic io_read(input logic [31:0] a, input logic [7:0] exp, input string name);
        drive(a, 8'h00, 1'b0);
        step();
        chk(name, 32'(cpu_din), 32'(exp));
    endtask

    logic [7:0] drain_exp [8];

    initial begin
        for (int i = 0; i < 131072; i++) ram_mem[i] = 8'h00;
        rst_in = 1'b1; rdy_in = 1'b1; tx_ready = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0;
        drive(32'h30010, 8'h00, 1'b0);
        step();
        step();
        chk("reset_cpu_din", 32'(cpu_din), 0);
        chk("reset_tx_valid", 32'(tx_valid), 0);
        chk("reset_buf_full", 32'(io_buffer_full), 0);
        chk("reset_rx_pop", 32'(rx_pop), 0);
        chk("reset_stop", 32'(program_stop), 0);
        chk("reset_overflow", 32'(tx_overflow), 0);

        // a, dout, wr, rdy, ram_en, ram_wr, cpu_din after the edge
        tbl[0]  = '{32'h00100, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00};
        tbl[1]  = '{32'h00100, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A};
        tbl[2]  = '{32'h001FF, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00};
        tbl[3]  = '{32'h001FF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC3};
        tbl[4]  = '{32'h00100, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A};
        tbl[5]  = '{32'h30010, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{32'h30000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{32'h00100, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{32'h00100, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{32'h00100, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[10] = '{32'h00100, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[11] = '{32'h00100, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[12] = '{32'h30004, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h07};
        tbl[13] = '{32'h30005, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[14] = '{32'h30008, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[15] = '{32'h00100, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A};

        rst_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].a, tbl[i].dout, tbl[i].wr);
            rdy_in = tbl[i].rdy;
            #2;
            chk($sformatf("vec%0d_ram_en", i), 32'(ram_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d_ram_wr", i), 32'(ram_wr), 32'(tbl[i].rwr));
            step();
            chk($sformatf("vec%0d_cpu_din", i), 32'(cpu_din), 32'(tbl[i].din));
        end
        rdy_in = 1'b1;
        chk("no_push_yet", 32'(tx_valid), 0);

        // 'H', 'i', 0x00 with the UART always ready
        tx_ready = 1'b1;
        io_write(32'h30000, 8'h48);
        chk("tx_h_valid", 32'(tx_valid), 1);
        chk("tx_h_data", 32'(tx_data), 32'h48);
        io_write(32'h30000, 8'h69);
        chk("tx_i_valid", 32'(tx_valid), 1);
        chk("tx_i_data", 32'(tx_data), 32'h69);
        io_write(32'h30000, 8'h00);
        chk("tx_zero_ignored", 32'(tx_valid), 0);

        // Fill with the UART stalled
        tx_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            io_write(32'h30000, 8'h41 + 8'(k));
            if (k == 4) chk("buf_full_at5", 32'(io_buffer_full), 0);
        end
        chk("buf_full_at6", 32'(io_buffer_full), 1);
        io_write(32'h30000, 8'h47);
        io_write(32'h30000, 8'h48);
        chk("no_overflow_at8", 32'(tx_overflow), 0);
        io_write(32'h30000, 8'h49);
        chk("overflow_at9", 32'(tx_overflow), 1);
        chk("head_after_ovf", 32'(tx_data), 32'h41);

        // Push and pop together while full
        tx_ready = 1'b1;
        io_write(32'h30000, 8'h5A);
        chk("full_pushpop_head", 32'(tx_data), 32'h42);

        // Drain while the CPU is stalled
        drain_exp = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h5A};
        drive(32'h00100, 8'h00, 1'b0);
        rdy_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d_valid", k), 32'(tx_valid), 1);
            chk($sformatf("drain%0d_data", k), 32'(tx_data), 32'(drain_exp[k]));
            #2;
            chk($sformatf("drain%0d_ram_en", k), 32'(ram_en), 0);
            step();
        end
        chk("drain_empty", 32'(tx_valid), 0);
        chk("drain_buf_full", 32'(io_buffer_full), 0);
        chk("overflow_sticky", 32'(tx_overflow), 1);
        rdy_in = 1'b1;

        // Counter snapshot and upper-byte reads
        force dut.counter = 32'h12345678;
        io_read(32'h30004, 8'h78, "cnt_byte0");
        release dut.counter;
        io_read(32'h30005, 8'h56, "cnt_byte1");
        io_read(32'h30006, 8'h34, "cnt_byte2");
        io_read(32'h30007, 8'h12, "cnt_byte3");

        // Halt write
        tx_ready = 1'b0;
        io_write(32'h30004, 8'h77);
        chk("stop_set", 32'(program_stop), 1);
        chk("stop_tx_valid", 32'(tx_valid), 1);
        chk("stop_tx_data", 32'(tx_data), 0);
        tx_ready = 1'b1;
        drive(32'h30010, 8'h00, 1'b0);
        step();
        step();
        step();
        chk("stop_drained", 32'(tx_valid), 0);
        chk("stop_held", 32'(program_stop), 1);

`ifdef IO_RX_EN
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        drive(32'h30000, 8'h00, 1'b0);
        #2;
        chk("rx_pop_pulse", 32'(rx_pop), 1);
        step();
        chk("rx_cpu_din", 32'(cpu_din), 32'h41);
        rx_valid = 1'b0;
        drive(32'h30010, 8'h00, 1'b0);
        #2;
        chk("rx_pop_low", 32'(rx_pop), 0);
        step();
`endif

        // Reset mid-drain, with reset winning over a stalled CPU
        tx_ready = 1'b0;
        io_write(32'h30000, 8'h31);
        io_write(32'h30000, 8'h32);
        io_write(32'h30000, 8'h33);
        chk("pre_reset_valid", 32'(tx_valid), 1);
        rst_in = 1'b1;
        rdy_in = 1'b0;
        drive(32'h30010, 8'h00, 1'b0);
        step();
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_stop", 32'(program_stop), 0);
        chk("rst_overflow", 32'(tx_overflow), 0);
        rst_in = 1'b0;
        rdy_in = 1'b1;
        tx_ready = 1'b1;
        io_read(32'h30004, 8'h00, "rst_counter");
        io_read(32'h30007, 8'h00, "rst_snap");
        chk("rst_still_empty", 32'(tx_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
